// File: rtl/mem_bus_tracer_pkg.sv
// ---------------------------------------------------------------------------
// mem_bus_tracer_pkg
// Shared constants for the memory bus tracer: record op encodings and
// default widths/depth matching the DA_VINCI memory bus.
// ---------------------------------------------------------------------------
package mem_bus_tracer_pkg;

    localparam int TRACE_DATA_WIDTH = 32;  // DATA_INDEX_LIMIT + 1
    localparam int TRACE_ADDR_WIDTH = 26;  // ADDRESS_INDEX_LIMIT + 1
    localparam int TRACE_DEPTH      = 16;
    localparam int TRACE_CNT_WIDTH  = 32;

    localparam logic TRACE_OP_READ  = 1'b0;
    localparam logic TRACE_OP_WRITE = 1'b1;

endpackage

// File: rtl/mem_bus_tracer_trace_fifo.sv
// ---------------------------------------------------------------------------
// trace_fifo
// Circular buffer with overwrite-on-full policy.
//   clk, srst        : clock, synchronous active-high reset
//   push, push_data  : append an entry (always accepted)
//   ready            : consumer accepts the head entry when valid
//   valid, head_data : head entry, driven combinationally from storage
//   overwrite        : pulse, a push discarded the oldest entry
// ---------------------------------------------------------------------------
module trace_fifo
    import mem_bus_tracer_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = TRACE_DEPTH
) (
    input  logic             clk,
    input  logic             srst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             ready,
    output logic             valid,
    output logic [WIDTH-1:0] head_data,
    output logic             overwrite
);

    localparam int AW = $clog2(DEPTH);

    // One extra pointer bit distinguishes full from empty.
    logic [AW:0]      wr_ptr_reg;
    logic [AW:0]      rd_ptr_reg;
    logic [WIDTH-1:0] mem [DEPTH];

    logic empty;
    logic full;
    logic pop;

    assign empty = (wr_ptr_reg == rd_ptr_reg);
    assign full  = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                   (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
    assign pop   = !empty && ready;

    // A simultaneous pop frees the slot, so only an unpopped full push
    // actually loses data.
    assign overwrite = push && full && !pop;

    assign valid     = !empty;
    assign head_data = empty ? '0 : mem[rd_ptr_reg[AW-1:0]];

    always_ff @(posedge clk) begin
        if (srst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + (AW+1)'(1);
            end
            // Overwrite on full advances the head just like a pop.
            if (pop || (push && full)) begin
                rd_ptr_reg <= rd_ptr_reg + (AW+1)'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_reg[AW-1:0]] <= push_data;
        end
    end

endmodule

// File: rtl/mem_bus_tracer.sv
// ---------------------------------------------------------------------------
// mem_bus_tracer
// Passive monitor of the DA_VINCI memory bus. Detects request phases,
// pushes one record per completed transaction into trace_fifo, and keeps
// saturating read/write counters plus sticky error flags.
//   CLK, RST, CLEAR    : clock, sync reset, sync clear (same effect)
//   ENABLE             : capture enable
//   ADDR/READ/WRITE/WDATA/RDATA : observed bus
//   TR_VALID/TR_READY  : drain handshake; TR_OP/ADDR/DATA/STAMP = head record
//   RD_CNT, WR_CNT     : completed transactions (saturating)
//   OVERFLOW, RW_ERR   : sticky flags
// ---------------------------------------------------------------------------
module mem_bus_tracer
    import mem_bus_tracer_pkg::*;
#(
    parameter int DATA_WIDTH = TRACE_DATA_WIDTH,
    parameter int ADDR_WIDTH = TRACE_ADDR_WIDTH,
    parameter int DEPTH      = TRACE_DEPTH,
    parameter int CNT_WIDTH  = TRACE_CNT_WIDTH
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  ENABLE,
    input  logic                  CLEAR,
    input  logic [ADDR_WIDTH-1:0] ADDR,
    input  logic                  READ,
    input  logic                  WRITE,
    input  logic [DATA_WIDTH-1:0] WDATA,
    input  logic [DATA_WIDTH-1:0] RDATA,
    output logic                  TR_VALID,
    input  logic                  TR_READY,
    output logic                  TR_OP,
    output logic [ADDR_WIDTH-1:0] TR_ADDR,
    output logic [DATA_WIDTH-1:0] TR_DATA,
    output logic [CNT_WIDTH-1:0]  TR_STAMP,
    output logic [CNT_WIDTH-1:0]  RD_CNT,
    output logic [CNT_WIDTH-1:0]  WR_CNT,
    output logic                  OVERFLOW,
    output logic                  RW_ERR
);

    localparam int REC_W = 1 + ADDR_WIDTH + DATA_WIDTH + CNT_WIDTH;

    logic srst;
    assign srst = RST || CLEAR;

    // Pending slot: the transaction currently being observed.
    logic                  pend_valid_reg;
    logic                  pend_op_reg;
    logic [ADDR_WIDTH-1:0] pend_addr_reg;
    logic [DATA_WIDTH-1:0] pend_data_reg;

    logic [CNT_WIDTH-1:0]  cycle_cnt_reg;
    logic [CNT_WIDTH-1:0]  rd_cnt_reg;
    logic [CNT_WIDTH-1:0]  wr_cnt_reg;
    logic                  overflow_reg;
    logic                  rw_err_reg;

    logic                  phase_cycle;
    logic                  cur_op;
    logic [DATA_WIDTH-1:0] cur_data;
    logic                  phase_break;
    logic                  push;
    logic                  overwrite;
    logic [REC_W-1:0]      push_rec;
    logic [REC_W-1:0]      head_rec;

    // READ and WRITE together is an error cycle, never a phase cycle.
    assign phase_cycle = ENABLE && (READ ^ WRITE);
    assign cur_op      = WRITE ? TRACE_OP_WRITE : TRACE_OP_READ;
    assign cur_data    = WRITE ? WDATA : RDATA;

    // The open phase ends when this cycle is not a continuation of it;
    // a change of op or address starts a new phase in the same cycle.
    assign phase_break = pend_valid_reg &&
                         (!phase_cycle || (cur_op != pend_op_reg) ||
                          (ADDR != pend_addr_reg));
    assign push        = ENABLE && phase_break;
    assign push_rec    = {pend_op_reg, pend_addr_reg, pend_data_reg, cycle_cnt_reg};

    always_ff @(posedge CLK) begin
        if (srst) begin
            pend_valid_reg <= 1'b0;
            pend_op_reg    <= TRACE_OP_READ;
            pend_addr_reg  <= '0;
            pend_data_reg  <= '0;
            cycle_cnt_reg  <= '0;
            rd_cnt_reg     <= '0;
            wr_cnt_reg     <= '0;
            overflow_reg   <= 1'b0;
            rw_err_reg     <= 1'b0;
        end else begin
            cycle_cnt_reg <= cycle_cnt_reg + CNT_WIDTH'(1);

            if (phase_cycle) begin
                pend_valid_reg <= 1'b1;
                pend_op_reg    <= cur_op;
                pend_addr_reg  <= ADDR;
                pend_data_reg  <= cur_data;
            end else begin
                pend_valid_reg <= 1'b0;
            end

            if (push) begin
                if (pend_op_reg == TRACE_OP_WRITE) begin
                    if (wr_cnt_reg != '1) wr_cnt_reg <= wr_cnt_reg + CNT_WIDTH'(1);
                end else begin
                    if (rd_cnt_reg != '1) rd_cnt_reg <= rd_cnt_reg + CNT_WIDTH'(1);
                end
            end

            if (overwrite)     overflow_reg <= 1'b1;
            if (READ && WRITE) rw_err_reg   <= 1'b1;
        end
    end

    trace_fifo #(
        .WIDTH (REC_W),
        .DEPTH (DEPTH)
    ) u_trace_fifo (
        .clk       (CLK),
        .srst      (srst),
        .push      (push),
        .push_data (push_rec),
        .ready     (TR_READY),
        .valid     (TR_VALID),
        .head_data (head_rec),
        .overwrite (overwrite)
    );

    assign {TR_OP, TR_ADDR, TR_DATA, TR_STAMP} = head_rec;

    assign RD_CNT   = rd_cnt_reg;
    assign WR_CNT   = wr_cnt_reg;
    assign OVERFLOW = overflow_reg;
    assign RW_ERR   = rw_err_reg;

endmodule
